// File: rtl/lsu_mem_port_pkg.sv
// Shared encodings for the LSU memory port: store size codes, load funct3 codes, FSM states.
package lsu_mem_port_pkg;

    typedef enum logic [1:0] {
        WRITE_IDLE = 2'b00,
        WRITE_BYTE = 2'b01,
        WRITE_HALF = 2'b10,
        WRITE_WORD = 2'b11
    } wsize_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_REQ    = 2'b01,
        S_WAIT_R = 2'b10,
        S_DONE   = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes and replication, load extraction/extension,
// and legality flags for the access described by addr/size/funct3.
module lsu_align
    import lsu_mem_port_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo_i,
    input  logic            is_store_i,
    input  logic [1:0]      wsize_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misalign_o,
    output logic            bad_f3_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        wstrb_o    = 4'b0000;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        bad_f3_o   = 1'b0;
        if (is_store_i) begin
            case (wsize_i)
                WRITE_BYTE: begin
                    wstrb_o = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                WRITE_HALF: begin
                    wstrb_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                    wdata_o    = {2{wdata_i[15:0]}};
                    misalign_o = addr_lo_i[0];
                end
                WRITE_WORD: begin
                    wstrb_o    = 4'b1111;
                    misalign_o = |addr_lo_i;
                end
                default: ;
            endcase
        end else begin
            case (funct3_i)
                F3_LB, F3_LBU: ;
                F3_LH, F3_LHU: misalign_o = addr_lo_i[0];
                F3_LW:         misalign_o = |addr_lo_i;
                default:       bad_f3_o   = 1'b1;
            endcase
        end
    end

    // Byte/half selected by shifting the word down to lane 0.
    always_comb begin
        rbyte = 8'(mem_rdata_i >> {addr_lo_i, 3'b000});
        rhalf = 16'(mem_rdata_i >> {addr_lo_i[1], 4'b0000});
        case (funct3_i)
            F3_LB:   rdata_o = {{(XLEN-8){rbyte[7]}}, rbyte};
            F3_LBU:  rdata_o = {{(XLEN-8){1'b0}}, rbyte};
            F3_LH:   rdata_o = {{(XLEN-16){rhalf[15]}}, rhalf};
            F3_LHU:  rdata_o = {{(XLEN-16){1'b0}}, rhalf};
            default: rdata_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Data-memory port for the single-cycle core: one registered bus transaction per
// load/store, core stalled until done, aborted with err on illegal access or timeout.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemRead,
    input  logic [1:0]      MemWrite,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic [XLEN-1:0] rdata,
    output logic            done,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                TMO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            is_store, cmd, illegal, accept, busy, tmo, capture;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata, al_rdata;
    logic            al_misalign, al_bad_f3;

    // A store code overrides MemRead when both are asserted.
    assign is_store = (MemWrite != WRITE_IDLE);
    assign cmd      = MemRead | is_store;
    assign illegal  = al_misalign | al_bad_f3;
    assign accept   = (state_q == S_IDLE) && cmd && !illegal;
    assign busy     = (state_q == S_REQ) || (state_q == S_WAIT_R);

    // Timeout is decided from the counter alone so mem_req never depends on mem_gnt.
    assign tmo      = TMO_EN && busy && (cnt_q == CNT_LAST);
    assign capture  = !tmo && (((state_q == S_REQ) && mem_gnt && !we_q && mem_rvalid) ||
                               ((state_q == S_WAIT_R) && mem_rvalid));

    lsu_align #(.XLEN(XLEN)) u_align (
        .addr_lo_i   (addr[1:0]),
        .is_store_i  (is_store),
        .wsize_i     (MemWrite),
        .funct3_i    (funct3),
        .wdata_i     (wdata),
        .mem_rdata_i (mem_rdata),
        .wstrb_o     (al_wstrb),
        .wdata_o     (al_wdata),
        .rdata_o     (al_rdata),
        .misalign_o  (al_misalign),
        .bad_f3_o    (al_bad_f3)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ: begin
                if (tmo)          state_d = S_IDLE;
                else if (mem_gnt) state_d = (we_q || mem_rvalid) ? S_DONE : S_WAIT_R;
            end
            S_WAIT_R: begin
                if (tmo)             state_d = S_IDLE;
                else if (mem_rvalid) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        mem_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = cmd & ~illegal;
                err   = cmd & illegal;
            end
            S_REQ: begin
                mem_req = ~tmo;
                stall   = ~tmo;
                err     = tmo;
            end
            S_WAIT_R: begin
                stall = ~tmo;
                err   = tmo;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Bus fields are loaded once at acceptance and held for the whole transaction.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (accept) begin
            we_d    = is_store;
            addr_d  = {addr[XLEN-1:2], 2'b00};
            wstrb_d = al_wstrb;
            wdata_d = al_wdata;
        end
        if (capture) rdata_d = al_rdata;
        cnt_d = '0;
        if (busy && ((state_d == S_REQ) || (state_d == S_WAIT_R))) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: completions and errors are scoreboarded by cycle.
module tb_lsu_mem_port;
    import lsu_mem_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic [1:0]  MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        string       tag;
        bit          is_err;
        bit          chk_data;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    lsu_mem_port #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit is_err, input bit chk_data,
                        input logic [31:0] rd, input int c);
        exp_t e;
        e.tag = tag; e.is_err = is_err; e.chk_data = chk_data; e.rdata = rd; e.cyc = c;
        sb.push_back(e);
    endtask

    // Every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && (done === 1'b1 || err === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'b0, done, err}, 32'b0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
                chkb({e.tag, "_err"}, err, e.is_err);
                chkb({e.tag, "_done"}, done, !e.is_err);
                if (e.chk_data) chk({e.tag, "_rdata"}, rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        MemRead = 1'b0; MemWrite = WRITE_IDLE; funct3 = 3'b000; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic store_op(input string tag, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] wd, input int gnt_wait, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wd, input bit stray);
        int n;
        tick();
        idle_in();
        MemWrite = size; addr = a; wdata = wd; mem_rvalid = stray;
        n = cyc;
        push(tag, 1'b0, 1'b0, 32'h0, n + 2 + gnt_wait);
        #1; chkb({tag, "_stall_cmd"}, stall, 1'b1);
        chkb({tag, "_req_cmd"}, mem_req, 1'b0);
        tick();
        for (int i = 0; i < gnt_wait; i++) begin
            mem_rvalid = stray;
            #1; chkb({tag, "_req_hold"}, mem_req, 1'b1);
            chk({tag, "_strb_hold"}, 32'(mem_wstrb), 32'(exp_strb));
            tick();
        end
        mem_gnt = 1'b1; mem_rvalid = 1'b0;
        #1; chkb({tag, "_req"}, mem_req, 1'b1);
        chkb({tag, "_we"}, mem_we, 1'b1);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_strb"}, 32'(mem_wstrb), 32'(exp_strb));
        chk({tag, "_wdata"}, mem_wdata, exp_wd);
        tick();
        idle_in(); mem_rvalid = stray;
        #1; chkb({tag, "_stall_done"}, stall, 1'b0);
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, input int gnt_wait, input int rv_wait,
                           input logic [31:0] exp);
        int n;
        tick();
        idle_in();
        MemRead = 1'b1; funct3 = f3; addr = a;
        n = cyc;
        push(tag, 1'b0, 1'b1, exp, n + 2 + gnt_wait + rv_wait);
        #1; chkb({tag, "_stall_cmd"}, stall, 1'b1);
        tick();
        for (int i = 0; i < gnt_wait; i++) begin
            #1; chkb({tag, "_req_hold"}, mem_req, 1'b1);
            tick();
        end
        mem_gnt = 1'b1;
        if (rv_wait == 0) begin mem_rvalid = 1'b1; mem_rdata = word; end
        #1; chkb({tag, "_req"}, mem_req, 1'b1);
        chkb({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_strb"}, 32'(mem_wstrb), 32'h0);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int i = 0; i < rv_wait; i++) begin
            if (i == rv_wait - 1) begin mem_rvalid = 1'b1; mem_rdata = word; end
            #1; chkb({tag, "_stall_wait"}, stall, 1'b1);
            chkb({tag, "_req_wait"}, mem_req, 1'b0);
            tick();
            mem_rvalid = 1'b0;
        end
        idle_in();
        #1; chkb({tag, "_stall_done"}, stall, 1'b0);
        tick();
    endtask

    task automatic illegal_op(input string tag, input logic mr, input logic [1:0] mw,
                              input logic [2:0] f3, input logic [31:0] a);
        tick();
        idle_in();
        MemRead = mr; MemWrite = mw; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
        push(tag, 1'b1, 1'b0, 32'h0, cyc);
        #1; chkb({tag, "_stall"}, stall, 1'b0);
        chkb({tag, "_req"}, mem_req, 1'b0);
        tick();
        idle_in();
        #1; chkb({tag, "_req_after"}, mem_req, 1'b0);
        chkb({tag, "_stall_after"}, stall, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chkb({tag, "_stall"}, stall, 1'b0);
        chkb({tag, "_done"}, done, 1'b0);
        chkb({tag, "_err"}, err, 1'b0);
        chkb({tag, "_req"}, mem_req, 1'b0);
        chkb({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_strb"}, 32'(mem_wstrb), 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst = 1'b1;
        idle_in();
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        store_op("sb", WRITE_BYTE, 32'h0000_1003, 32'h0000_00A5, 0, 4'b1000, 32'hA5A5_A5A5, 1'b0);
        store_op("sh", WRITE_HALF, 32'h0000_8002, 32'h1234_BEEF, 1, 4'b1100, 32'hBEEF_BEEF, 1'b0);
        load_op("lb",  F3_LB,  32'h0000_2001, 32'h0000_F700, 0, 2, 32'hFFFF_FFF7);
        load_op("lbu", F3_LBU, 32'h0000_2001, 32'h0000_F700, 0, 2, 32'h0000_00F7);
        load_op("lhu_wait", F3_LHU, 32'h0000_3002, 32'h8001_0000, 1, 1, 32'h0000_8001);
        load_op("lh",  F3_LH,  32'h0000_3002, 32'h8001_0000, 0, 0, 32'hFFFF_8001);

        illegal_op("sw_mis", 1'b0, WRITE_WORD, 3'b000, 32'h0000_4002);
        illegal_op("lw_f3",  1'b1, WRITE_IDLE, 3'b011, 32'h0000_4000);
        illegal_op("sh_mis", 1'b0, WRITE_HALF, 3'b000, 32'h0000_4001);

        // Load granted but never answered: abort on the fourth busy cycle.
        tick();
        idle_in();
        MemRead = 1'b1; funct3 = F3_LW; addr = 32'h0000_6000;
        n = cyc;
        push("tmo", 1'b1, 1'b0, 32'h0, n + 4);
        tick();
        mem_gnt = 1'b1;
        #1; chkb("tmo_req", mem_req, 1'b1);
        tick();
        mem_gnt = 1'b0;
        #1; chkb("tmo_stall_w1", stall, 1'b1);
        tick();
        #1; chkb("tmo_stall_w2", stall, 1'b1);
        tick();
        #1; chkb("tmo_stall_abort", stall, 1'b0);
        chkb("tmo_req_abort", mem_req, 1'b0);
        chk("tmo_rdata_kept", rdata, 32'hFFFF_8001);

        store_op("sw_after_tmo", WRITE_WORD, 32'h0000_5000, 32'hDEAD_BEEF, 1, 4'b1111,
                 32'hDEAD_BEEF, 1'b1);

        // Reset while waiting for read data.
        tick();
        idle_in();
        MemRead = 1'b1; funct3 = F3_LHU; addr = 32'h0000_7000;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1; chkb("rstw_stall", stall, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_in();
        #1; chk_all_zero("rstw");
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1; chkb("rstw_late_done", done, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        #1; chkb("rstw_late_done2", done, 1'b0);
        chk("rstw_late_rdata", rdata, 32'h0);

        repeat (2) tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Responder end of the controller's memory command (MemRead, 2-bit MemWrite size code, funct3).
- Turns one load/store per instruction into a registered valid/grant/rvalid transaction on the data-memory bus.
- Generates byte strobes and sign/zero-extends load data.
- Stalls the single-cycle core until the access completes.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- TIMEOUT, 255, max cycles in REQ+WAIT_R before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- MemRead  in  1  load command from controller
- MemWrite  in  2  store size: 00 idle, 01 byte, 10 half, 11 word
- funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- addr  in  XLEN  byte address (ALU result)
- wdata  in  XLEN  store data (rs2)
- stall  out  1  hold PC/instruction this cycle
- rdata  out  XLEN  extended load result, valid while done=1
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: misaligned, bad funct3 or timeout
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}
- mem_wstrb  out  4  byte-lane enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read word

Behaviour:
- FSM states: IDLE, REQ, WAIT_R, DONE.
- Reset: state IDLE. All outputs 0: stall, rdata, done, err, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata. Timeout counter 0.
- Command definition: cmd = MemRead | (MemWrite != 00).
  - Store wins if both are set.
- Core contract: while stall=1 the core holds all inputs stable.
- IDLE with cmd and legal access:
  - stall=1 combinationally.
  - Next: REQ; bus outputs registered from the inputs.
- IDLE with cmd and illegal access:
  - Illegal = half with addr[0]=1; word/LW with addr[1:0]!=0; load funct3 not in {000,001,010,100,101}.
  - Response: err=1 for that cycle, no bus activity, stall=0, stays IDLE.
- REQ:
  - mem_req=1; stall=1.
  - No gnt: hold all bus outputs stable.
  - gnt and store: DONE.
  - gnt and load with rvalid the same cycle: capture, then DONE.
  - gnt and load without rvalid: WAIT_R; mem_req drops.
- WAIT_R: stall=1. On mem_rvalid: capture extended data into rdata, then DONE.
- DONE: done=1, stall=0, rdata held. Next: IDLE.
  - The instruction retires this cycle; the next instruction is sampled in IDLE.
- Store strobes:
  - Byte: 0001 << addr[1:0]; wdata byte replicated ×4.
  - Half: 0011 << {addr[1],1'b0}; wdata half replicated ×2.
  - Word: 1111; wdata as is.
- Load extraction:
  - Byte = mem_rdata >> (8*addr[1:0]); half = mem_rdata >> (16*addr[1]).
  - LB/LH sign-extend, LBU/LHU zero-extend.
- Loads: mem_wstrb=0000, mem_we=0.
- Latency from command cycle N:
  - Store with gnt at N+1: done at N+2.
  - Load with gnt+rvalid at N+1: done at N+2.
  - Each extra wait cycle adds one.
- Timeout:
  - Counter increments each cycle in REQ/WAIT_R.
  - When it reaches TIMEOUT: err=1, done=0, mem_req=0, state IDLE, stall=0.
  - Counter clears on leaving those states.
- Stray/late mem_rvalid in IDLE, REQ-before-gnt or DONE: ignored.
- rst in any state: IDLE next edge, mem_req deasserted, captured data discarded.

Decomposition:
- Shared defines get:
  - WRITE_IDLE/BYTE/HALF/WORD size codes.
  - Load funct3 codes LB/LH/LW/LBU/LHU.
  - LSU state encoding.
- One natural sub-module: lsu_align.
  - Purely combinational; given addr, size and wdata/mem_rdata, produces wstrb, replicated wdata, extended rdata and the misalign flag.
  - lsu_mem_port holds the FSM, registers and timeout counter.

Test Plan:
- SB addr=0x1003 wdata=0x000000A5, gnt immediate -> mem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, we=1; stall 2 cycles; done at N+2.
- LB addr=0x2001, gnt at N+1, rvalid N+3 with 0x12348000... use 0x0000F700 -> rdata=0xFFFFFFF7, done N+4; same access as LBU -> 0x000000F7.
- LH addr=0x3002, mem_rdata=0x8001_0000 with gnt+rvalid same cycle -> rdata=0xFFFF8001 at N+2.
- SW addr=0x4002 -> err pulse cycle N, mem_req never asserted, stall=0; LW funct3=011 -> same.
- TIMEOUT=4, load granted, rvalid never -> err at 4th REQ/WAIT cycle, back in IDLE; subsequent SW 0x5000 completes normally and ignores a late rvalid.
- rst asserted in WAIT_R -> next cycle IDLE, all outputs 0, later rvalid produces no done.
